// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between an alu_seq requester and the alu_seq block
interface alu_seq_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] op;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic carry;
  logic zero;
  modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, result, carry, zero);
  modport slave (input in_valid, a, b, op, out_ready, output in_ready, out_valid, result, carry, zero);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and a WIDTH-step shift-add multiplier
module alu_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, mplier_q, mplier_d, alu_res;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [SW-1:0] cnt_q, cnt_d, s;
  logic carry_q, carry_d, zero_q, zero_d, alu_c;
  logic [WIDTH:0] sum, diff, shl_w, shr_w;
  always_comb begin
    s = bus.b[SW-1:0];
    sum = {1'b0, bus.a} + {1'b0, bus.b};
    diff = {1'b0, bus.a} - {1'b0, bus.b};
    shl_w = {1'b0, bus.a} << s;
    shr_w = {bus.a, 1'b0} >> s;
    alu_res = bus.op == 3'd0 ? sum[WIDTH-1:0] :
              bus.op == 3'd1 ? diff[WIDTH-1:0] :
              bus.op == 3'd2 ? bus.a & bus.b :
              bus.op == 3'd3 ? bus.a | bus.b :
              bus.op == 3'd4 ? bus.a ^ bus.b :
              bus.op == 3'd5 ? shl_w[WIDTH-1:0] : shr_w[WIDTH:1];
    alu_c = bus.op == 3'd0 ? sum[WIDTH] :
            bus.op == 3'd1 ? diff[WIDTH] :
            bus.op == 3'd5 ? shl_w[WIDTH] :
            bus.op == 3'd6 ? shr_w[0] : 1'b0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    carry_d = carry_q;
    zero_d = zero_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        if (bus.op == 3'd7) begin
          state_d = MUL;
          acc_d = '0;
          mcand_d = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d = '0;
        end else begin
          state_d = HOLD;
          result_d = alu_res;
          carry_d = alu_c;
          zero_d = alu_res == '0;
        end
      end
      MUL: begin
        acc_d = acc_step;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = HOLD;
          result_d = acc_step[WIDTH-1:0];
          carry_d = |acc_step[2*WIDTH-1:WIDTH];
          zero_d = acc_step[WIDTH-1:0] == '0;
        end
      end
      HOLD: state_d = bus.out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      result_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == HOLD;
  assign bus.result = result_q;
  assign bus.carry = carry_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, corner sequences and random ops checked against an arithmetic model
module tb_alu_seq;
  logic clk;
  logic rst_n;
  int checks;
  int errors;
  alu_seq_if #(.WIDTH(8)) bus();
  alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int bp;
    logic [7:0] res;
    logic c;
    logic z;
  } vec_t;
  vec_t vecs [14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  function automatic void model(input int a, input int b, input int op, output logic [7:0] r, output logic c);
    int s;
    int full;
    s = b % 8;
    full = 0;
    r = 8'd0;
    c = 1'b0;
    case (op)
      0: begin full = a + b; r = full[7:0]; c = full > 255; end
      1: begin full = a - b; r = full[7:0]; c = a < b; end
      2: r = 8'(a & b);
      3: r = 8'(a | b);
      4: r = 8'(a ^ b);
      5: begin full = a * (1 << s); r = full[7:0]; c = s != 0 && full[8]; end
      6: begin full = a / (1 << s); r = full[7:0]; c = s != 0 && ((a / (1 << (s - 1))) % 2 == 1); end
      default: begin full = a * b; r = full[7:0]; c = full > 255; end
    endcase
  endfunction
  task automatic junk_inputs();
    bus.in_valid = 1'b1;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.op = 3'($urandom);
  endtask
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop, input int bp,
                        input logic [7:0] er, input logic ec, input logic ez, input string tag);
    int edges;
    chk({tag, " in_ready_before"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a = ia;
    bus.b = ib;
    bus.op = iop;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    edges = 0;
    junk_inputs();
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      junk_inputs();
    end
    chk({tag, " latency"}, 32'(edges), iop == 3'd7 ? 8 : 0);
    chk({tag, " result"}, 32'(bus.result), 32'(er));
    chk({tag, " carry"}, 32'(bus.carry), 32'(ec));
    chk({tag, " zero"}, 32'(bus.zero), 32'(ez));
    for (int i = 0; i < bp; i++) begin
      junk_inputs();
      @(posedge clk); #1;
      chk({tag, " bp_valid"}, 32'(bus.out_valid), 1);
      chk({tag, " bp_in_ready"}, 32'(bus.in_ready), 0);
      chk({tag, " bp_result"}, {23'd0, bus.carry, bus.zero, bus.result}, {23'd0, ec, ez, er});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " valid_drop"}, 32'(bus.out_valid), 0);
    chk({tag, " in_ready_after"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    logic [7:0] ra, rb, er;
    logic [2:0] rop;
    logic ec;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    vecs[0]  = '{8'd200, 8'd100, 3'd0, 0, 8'd44,  1'b1, 1'b0};
    vecs[1]  = '{8'd5,   8'd7,   3'd1, 0, 8'd254, 1'b1, 1'b0};
    vecs[2]  = '{8'd7,   8'd7,   3'd1, 0, 8'd0,   1'b0, 1'b1};
    vecs[3]  = '{8'd15,  8'd17,  3'd7, 0, 8'd255, 1'b0, 1'b0};
    vecs[4]  = '{8'd16,  8'd16,  3'd7, 2, 8'd0,   1'b1, 1'b1};
    vecs[5]  = '{8'h81,  8'd9,   3'd5, 0, 8'h02,  1'b1, 1'b0};
    vecs[6]  = '{8'h01,  8'd0,   3'd6, 0, 8'h01,  1'b0, 1'b0};
    vecs[7]  = '{8'hF0,  8'h3C,  3'd2, 0, 8'h30,  1'b0, 1'b0};
    vecs[8]  = '{8'h0F,  8'hF0,  3'd3, 0, 8'hFF,  1'b0, 1'b0};
    vecs[9]  = '{8'hAA,  8'hAA,  3'd4, 5, 8'h00,  1'b0, 1'b1};
    vecs[10] = '{8'h80,  8'd7,   3'd6, 0, 8'h01,  1'b0, 1'b0};
    vecs[11] = '{8'hC0,  8'd7,   3'd6, 0, 8'h01,  1'b1, 1'b0};
    vecs[12] = '{8'd255, 8'd1,   3'd0, 1, 8'd0,   1'b1, 1'b1};
    vecs[13] = '{8'd255, 8'd255, 3'd7, 0, 8'd1,   1'b1, 1'b0};
    #12;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_result", 32'(bus.result), 0);
    chk("reset_flags", {30'd0, bus.carry, bus.zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 1);
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].bp, vecs[i].res, vecs[i].c, vecs[i].z, $sformatf("vec%0d", i));
    run_op(8'd1, 8'd2, 3'd0, 0, 8'd3, 1'b0, 1'b0, "pre_abort_add");
    bus.in_valid = 1'b1;
    bus.a = 8'd15;
    bus.b = 8'd17;
    bus.op = 3'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_in_ready", 32'(bus.in_ready), 0);
    chk("abort_stale_result", 32'(bus.result), 3);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_result", 32'(bus.result), 0);
    chk("abort_flags", {30'd0, bus.carry, bus.zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", {23'd0, bus.out_valid, bus.result}, 0);
    end
    run_op(8'd16, 8'd3, 3'd0, 0, 8'd19, 1'b0, 1'b0, "abort_hold_add");
    bus.in_valid = 1'b1;
    bus.a = 8'd9;
    bus.b = 8'd9;
    bus.op = 3'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hold_abort_pre_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("hold_abort_valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("hold_abort_quiet", 32'(bus.out_valid), 0);
    for (int i = 0; i < 80; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = 3'($urandom);
      model(int'(ra), int'(rb), int'(rop), er, ec);
      run_op(ra, rb, rop, int'($urandom_range(0, 3)), er, ec, er == 8'd0, $sformatf("rnd%0d_op%0d", i, rop));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001: Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, 4 to 32.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  reset; asynchronous, active-low.
REQ-004: in_valid  input  1  request present on a, b, op.
REQ-005: in_ready  output  1  block can accept a request this cycle.
REQ-006: a  input  WIDTH  operand A, unsigned.
REQ-007: b  input  WIDTH  operand B, unsigned; shift ops use b mod WIDTH.
REQ-008: op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-009: out_valid  output  1  result, carry and zero are valid.
REQ-010: out_ready  input  1  consumer takes the result this cycle.
REQ-011: result  output  WIDTH  registered result.
REQ-012: carry  output  1  carry/borrow/shift-out/multiply-overflow flag.
REQ-013: zero  output  1  high when result == 0.

Function
REQ-014: FSM states SHALL be IDLE, MUL, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015: Accept = in_valid && in_ready at a rising edge; a, b, op SHALL be captured then; later input changes SHALL have no effect on the operation in flight.
REQ-016: IDLE + accept of a non-MUL op -> HOLD; result and flags SHALL be registered at the accepting edge, so out_valid is high in the next cycle (latency 1).
REQ-017: IDLE + accept of MUL -> MUL; one shift-add step per cycle for WIDTH cycles; MUL -> HOLD on the WIDTH-th step edge, so out_valid rises WIDTH cycles after the accepting edge.
REQ-018: HOLD: out_valid = 1; result, carry, zero SHALL stay stable until out_ready = 1; on out_valid && out_ready -> IDLE, out_valid low next cycle.
REQ-019: No second request is accepted while in MUL or HOLD; in_valid in those states SHALL be ignored, not queued.
REQ-020: out_valid SHALL come from a register, with no combinational path from out_ready or in_valid.
REQ-021: ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-022: SUB: result = (a-b) mod 2^WIDTH; carry = 1 iff a < b (borrow).
REQ-023: AND/OR/XOR: bitwise; carry = 0.
REQ-024: SHL/SHR: logical shift by s = b mod WIDTH, zero fill; carry = last bit shifted out; s = 0 gives result = a, carry = 0.
REQ-025: MUL: result = low WIDTH bits of a*b; carry = 1 iff high WIDTH bits of the 2*WIDTH product are nonzero.
REQ-026: zero SHALL be computed from the final registered result for every op.
REQ-027: For WIDTH <= 8 with op[2] = 0, results SHALL match the 2-bit-opcode ALU (ADD, SUB, AND, OR) bit for bit.

Reset
REQ-028: rst_n low SHALL immediately force IDLE, out_valid = 0, result = 0, carry = 0, zero = 0, and clear all MUL accumulator/counter state.
REQ-029: Reset during MUL or HOLD SHALL abort the operation; no partial or stale result SHALL appear after release.
REQ-030: in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (WIDTH = 8)
REQ-031: ADD a=200, b=100, out_ready=1 -> result 44, carry 1, zero 0, out_valid exactly 1 cycle after accept, in_ready back to 1 the cycle after.
REQ-032: SUB 5-7 -> result 254, carry 1; SUB 7-7 -> result 0, zero 1, carry 0.
REQ-033: MUL 15*17 -> result 255, carry 0, out_valid 8 cycles after accept; MUL 16*16 -> result 0, carry 1, zero 1.
REQ-034: SHL a=0x81, b=9 (s=1) -> result 0x02, carry 1; SHR a=0x01, b=0 -> result 0x01, carry 0.
REQ-035: Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid with new ops -> result/flags stable, in_ready 0, new ops not accepted; out_ready=1 -> out_valid drops next cycle.
REQ-036: rst_n low in the 3rd MUL cycle -> out_valid 0 and result 0 immediately; after release, in_ready 1 and out_valid stays 0 until a new accept.
